// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder with a one-word holding buffer so back-to-back words stream gap-free.
// Define SER_LSB_FIRST_EN to shift words out LSB first (default is MSB first).
module seq_bit_serializer #(
  parameter int WIDTH   = 8,
  parameter int BIT_DIV = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  output logic             o_bit_out,
  output logic             o_bit_valid,
  output logic             o_word_start,
  output logic             o_busy
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [DW-1:0]    r_div_cnt, w_div_cnt_nxt;
  logic             r_word_start, w_word_start_nxt;
  logic             w_xfer, w_div_wrap, w_last, w_active, w_cur_bit;
  logic [WIDTH-1:0] w_shifted;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_word_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_full  <= w_hold_full_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_div_cnt    <= w_div_cnt_nxt;
      r_word_start <= w_word_start_nxt;
    end
  end

`ifdef SER_LSB_FIRST_EN
  assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
  assign w_cur_bit = r_shift[0];
`else
  assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
  assign w_cur_bit = r_shift[WIDTH-1];
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_hold_nxt       = r_hold;
    w_hold_full_nxt  = r_hold_full;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_div_cnt_nxt    = r_div_cnt;
    w_word_start_nxt = 1'b0;
    // Reset is applied by the register stage, so no rst term is needed here.
    w_xfer     = i_din_valid & ~r_hold_full;
    w_div_wrap = (r_div_cnt == DIV_LAST);
    w_last     = w_div_wrap & (r_bit_cnt == BIT_LAST);

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_shift_nxt      = i_din;
          w_bit_cnt_nxt    = '0;
          w_div_cnt_nxt    = '0;
          w_word_start_nxt = 1'b1;
          w_state_nxt      = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_bit_cnt_nxt = '0;
          w_div_cnt_nxt = '0;
          if (r_hold_full) begin
            w_shift_nxt      = r_hold;
            w_hold_full_nxt  = 1'b0;
            w_word_start_nxt = 1'b1;
          end else if (w_xfer) begin
            w_shift_nxt      = i_din;
            w_word_start_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          if (w_div_wrap) begin
            w_div_cnt_nxt = '0;
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            w_shift_nxt   = w_shifted;
          end else begin
            w_div_cnt_nxt = r_div_cnt + 1'b1;
          end
          if (w_xfer) begin
            w_hold_nxt      = i_din;
            w_hold_full_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are forced quiet for the whole time rst is high, not just after the first edge.
    w_active     = (r_state == S_SHIFT) & ~i_rst;
    o_din_ready  = ~r_hold_full & ~i_rst;
    o_bit_valid  = w_active;
    o_bit_out    = w_active & w_cur_bit;
    o_word_start = r_word_start & ~i_rst;
    o_busy       = ((r_state == S_SHIFT) | r_hold_full) & ~i_rst;
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: two instances (BIT_DIV=1 and 3) checked every cycle against a queue model.
// Honours SER_LSB_FIRST_EN so the same literal bit patterns apply in both orderings.
module tb_seq_bit_serializer;
  localparam int W = 8;
`ifdef SER_LSB_FIRST_EN
  localparam logic [7:0] W1 = 8'h0D;
  localparam logic [7:0] W2 = 8'hD0;
`else
  localparam logic [7:0] W1 = 8'hB0;
  localparam logic [7:0] W2 = 8'h0B;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  din  [2];
  logic        dv   [2];
  logic        rdy  [2];
  logic        bout [2];
  logic        bval [2];
  logic        ws   [2];
  logic        bsy  [2];
  logic [31:0] h_v  [2];
  logic [31:0] h_b  [2];
  logic [31:0] h_ws [2];
  logic [31:0] h_r  [2];

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int DIV = (k == 0) ? 1 : 3;

    seq_bit_serializer #(.WIDTH(W), .BIT_DIV(DIV)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_din        (din[k]),
      .i_din_valid  (dv[k]),
      .o_din_ready  (rdy[k]),
      .o_bit_out    (bout[k]),
      .o_bit_valid  (bval[k]),
      .o_word_start (ws[k]),
      .o_busy       (bsy[k])
    );

    // Model: q[0] is the word on the wire, q[1] the buffered one; p counts cycles into q[0].
    logic [7:0] q[$];
    int         p = 0;
    bit         m_xf;
    logic [7:0] cw;
    int         bi;
    logic       e_v, e_b, e_ws, e_r, e_bit;

    always @(posedge clk) begin
      if (rst) begin
        q.delete();
        p = 0;
      end else begin
        m_xf = dv[k] && (q.size() < 2);
        if (q.size() > 0) begin
          p++;
          if (p == W * DIV) begin
            void'(q.pop_front());
            p = 0;
          end
        end
        if (m_xf) q.push_back(din[k]);
      end
    end

    always @(negedge clk) begin
      e_bit = 1'b0;
      if (q.size() > 0) begin
        cw = q[0];
        bi = p / DIV;
`ifdef SER_LSB_FIRST_EN
        e_bit = cw[bi];
`else
        e_bit = cw[7 - bi];
`endif
      end
      e_v  = !rst && (q.size() > 0);
      e_b  = e_v && e_bit;
      e_ws = e_v && (p == 0);
      e_r  = !rst && (q.size() < 2);
      chk($sformatf("d%0d bit_valid", k), 32'(bval[k]), 32'(e_v));
      chk($sformatf("d%0d bit_out", k), 32'(bout[k]), 32'(e_b));
      chk($sformatf("d%0d word_start", k), 32'(ws[k]), 32'(e_ws));
      chk($sformatf("d%0d din_ready", k), 32'(rdy[k]), 32'(e_r));
      chk($sformatf("d%0d busy", k), 32'(bsy[k]), 32'(e_v));
      h_v[k]  = {h_v[k][30:0], bval[k]};
      h_b[k]  = {h_b[k][30:0], bout[k]};
      h_ws[k] = {h_ws[k][30:0], ws[k]};
      h_r[k]  = {h_r[k][30:0], rdy[k]};
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] w);
    @(posedge clk);
    #1;
    din[k] = w;
    dv[k]  = 1'b1;
    @(posedge clk);
    #1;
    dv[k] = 1'b0;
  endtask

  initial begin
    logic pre;
    din[0] = '0; din[1] = '0;
    dv[0]  = 1'b0; dv[1] = 1'b0;

    // reset state
    wait_neg(3);
    chk("rst ready0", 32'(rdy[0]), 32'd0);
    chk("rst valid1", 32'(bval[1]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_neg(1);
    chk("post-rst ready0", 32'(rdy[0]), 32'd1);
    chk("post-rst ready1", 32'(rdy[1]), 32'd1);

    // single word, cycles 1..9
    send(0, W1);
    wait_neg(9);
    chk("single bits", h_b[0][8:0], 32'b1011_0000_0);
    chk("single start", h_ws[0][8:0], 32'b1000_0000_0);
    chk("single valid", h_v[0][8:0], 32'b1111_1111_0);
    wait_neg(2);

    // back-to-back through the holding buffer, cycles 1..17
    @(posedge clk);
    #1 din[0] = W1; dv[0] = 1'b1;
    @(posedge clk);
    #1 din[0] = W2;
    @(posedge clk);
    #1 dv[0] = 1'b0;
    wait_neg(16);
    chk("b2b valid", h_v[0][16:0], 32'h1FFFE);
    chk("b2b bits", h_b[0][16:0], {15'd0, 16'b1011_0000_0000_1011, 1'b0});
    chk("b2b start", h_ws[0][16:0], 32'h10100);
    chk("b2b ready", h_r[0][16:0], 32'h101FF);
    wait_neg(2);

    // word presented exactly on the last-bit edge, hold empty
    send(0, W1);
    repeat (7) @(posedge clk);
    #1 din[0] = W2; dv[0] = 1'b1;
    @(posedge clk);
    #1 dv[0] = 1'b0;
    wait_neg(9);
    chk("bnd valid", h_v[0][16:0], 32'h1FFFE);
    chk("bnd bits", h_b[0][16:0], {15'd0, 16'b1011_0000_0000_1011, 1'b0});
    chk("bnd start", h_ws[0][16:0], 32'h10100);
    chk("bnd ready", h_r[0][16:0], 32'h1FFFF);
    wait_neg(2);

    // bit stretching with BIT_DIV=3 (A5 is its own bit reverse)
    send(1, 8'hA5);
    wait_neg(25);
    chk("div3 bits", h_b[1][24:0], {7'd0, 24'b111000111000000111000111, 1'b0});
    chk("div3 valid", h_v[1][24:0], {7'd0, 24'hFFFFFF, 1'b0});
    chk("div3 start", h_ws[1][24:0], {7'd0, 1'b1, 24'd0});
    wait_neg(2);

    // reset during bit 4 with the holding buffer full
    send(1, 8'hA5);
    send(1, 8'h3C);
    repeat (7) @(posedge clk);
    #1;
    chk("mid hold full", 32'(rdy[1]), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_neg(1);
    chk("mid valid", 32'(bval[1]), 32'd0);
    chk("mid busy", 32'(bsy[1]), 32'd0);
    chk("mid ready", 32'(rdy[1]), 32'd1);
    wait_neg(10);
    chk("mid no stale", h_v[1][10:0], 32'd0);

    // randomized traffic, din held stable while stalled
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        pre = rdy[k];
        @(posedge clk);
        #1;
        rst = ($urandom_range(0, 149) == 0);
        if (!(dv[k] && !pre)) begin
          dv[k]  = ($urandom_range(0, 3) != 0);
          din[k] = 8'($urandom);
        end
      end
      dv[k] = 1'b0;
      rst   = 1'b0;
      repeat (60) @(posedge clk);
    end

    wait_neg(1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit at a time on a single-bit stream (bit_out), which drives the detector's serial input.
- A one-entry holding buffer lets back-to-back words stream with no idle gap between them.
- When no word is active, the stream idles at 0, which cannot advance the detector out of its reset state.

Parameters:
- WIDTH, 8, bits per parallel word; legal range 2..32.
- BIT_DIV, 1, clock cycles each bit is held on bit_out; legal range 1..256.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept a word this cycle.
- bit_out  output  1  serial data bit; 0 when bit_valid=0.
- bit_valid  output  1  bit_out carries a live data bit.
- word_start  output  1  one-cycle pulse, high during the first cycle of the first bit of each word.
- busy  output  1  shifter active or holding buffer full.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all registers cleared.
  - While rst=1, the outputs are din_ready=0, bit_out=0, bit_valid=0, word_start=0, busy=0.
  - din_ready=1 in the first cycle after rst deasserts.
  - Reset mid-word aborts the word immediately and discards the holding buffer; no partial bits are emitted afterwards.
- Handshake:
  - A word transfers on a rising edge where din_valid=1 and din_ready=1.
  - din_ready = ~hold_full; it has no combinational path from din_valid.
  - din must stay stable while din_valid=1 and din_ready=0.
- State machine:
  - States are IDLE and SHIFT.
  - IDLE: bit_out=0, bit_valid=0. On a transfer, load din into the shift register, clear bit_cnt and div_cnt, and go to SHIFT.
  - SHIFT:
    - bit_valid=1; bit_out = current MSB of the shift register.
    - div_cnt counts 0..BIT_DIV-1. On wrap it shifts the register left by 1 and increments bit_cnt.
    - At the last bit (bit_cnt=WIDTH-1 and div_cnt=BIT_DIV-1):
      - If hold_full, load the hold word into the shifter, clear hold_full, and stay in SHIFT.
      - Else, if a transfer occurs on the same edge, load din directly into the shifter and stay in SHIFT.
      - Otherwise go to IDLE.
    - A transfer in SHIFT at any other edge writes the holding buffer and sets hold_full.
- Latency: a word transferred at edge T has its first bit on bit_out during the cycle after T. Each bit lasts exactly BIT_DIV cycles; one word occupies WIDTH*BIT_DIV cycles.
- No gap: consecutive words produce uninterrupted bit_valid.
- word_start: high in the first cycle after any shifter load.
- busy = (state==SHIFT) | hold_full.
- Counter widths:
  - bit_cnt is clog2(WIDTH) bits.
  - div_cnt is clog2(BIT_DIV) bits, minimum 1.
  - No counter may exceed its terminal value.

Optional Feature:
- Macro SER_LSB_FIRST_EN.
- Defined: words shift out LSB first; the shifter shifts right and bit_out = current LSB.
- Undefined (default): MSB first, as described above.
- Handshake, timing and counters are identical in both cases.

Test Plan:
- Reset then single word: WIDTH=8, BIT_DIV=1, transfer 8'hB0 at edge 0 -> bit_out 1,0,1,1,0,0,0,0 in cycles 1..8 with bit_valid=1; word_start high in cycle 1 only; cycle 9 bit_valid=0, bit_out=0; downstream detector out=1 for one cycle after the 4th bit.
- Back-to-back: din_valid held with 8'hB0, then 8'h0B presented next cycle -> B0 accepted at edge 0, 0B accepted at edge 1 into hold; din_ready=0 in cycles 2..8; 16 consecutive bit_valid cycles 1..16; word_start pulses in cycles 1 and 9.
- Boundary transfer: present a new word exactly at the last-bit edge of the previous word with hold empty -> loaded directly into the shifter, no bubble in bit_valid, hold stays empty, din_ready stays 1.
- Bit stretching: BIT_DIV=3, transfer 8'hA5 -> each bit held 3 cycles; pattern 1,1,1,0,0,0,1,1,1,... for 24 cycles; then IDLE.
- Reset mid-operation: rst=1 during bit 4 of a word with hold full -> next cycle bit_valid=0, busy=0; after release din_ready=1 and no stale bits emitted.
- SER_LSB_FIRST_EN defined, transfer 8'h0D -> bit_out 1,0,1,1,0,0,0,0.
